// File: rtl/calc1_core.sv
// calc1_core: four-port 32-bit add/subtract/shift calculator sharing one fixed-priority ALU.
// Define CALC1_SHIFT_EN to build the shifter for commands 5 and 6; otherwise they answer as invalid.
module calc1_core (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:31] out_data2,
  output logic [0:31] out_data3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp1,
  output logic [0:1]  out_resp2,
  output logic [0:1]  out_resp3,
  output logic [0:1]  out_resp4
);
  localparam int NP = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_PEND} state_e;

  logic [0:3]  cmd_in  [NP];
  logic [0:31] data_in [NP];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  state_e      state_q [NP], state_d [NP];
  logic [0:3]  cmd_q   [NP], cmd_d   [NP];
  logic [0:31] op1_q   [NP], op1_d   [NP];
  logic [0:31] op2_q   [NP], op2_d   [NP];
  logic [0:1]  resp_q  [NP], resp_d  [NP];
  logic [0:31] res_q   [NP], res_d   [NP];

  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic [0:3]  alu_cmd;
  logic [0:31] alu_a, alu_b, alu_data;
  logic [0:1]  alu_resp;
  logic [32:0] alu_sum;

  // Scanning downward leaves the lowest-numbered pending port as the winner.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (state_q[i] == ST_PEND) begin
        grant_vld = 1'b1;
        grant_idx = 2'(i);
      end
    end
  end

  always_comb begin
    alu_cmd  = cmd_q[grant_idx];
    alu_a    = op1_q[grant_idx];
    alu_b    = op2_q[grant_idx];
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    alu_resp = 2'd3;
    alu_data = '0;
    case (alu_cmd)
      4'd1: begin
        if (alu_sum[32]) begin
          alu_resp = 2'd2;
        end else begin
          alu_resp = 2'd1;
          alu_data = alu_sum[31:0];
        end
      end
      4'd2: begin
        if (alu_b > alu_a) begin
          alu_resp = 2'd2;
        end else begin
          alu_resp = 2'd1;
          alu_data = alu_a - alu_b;
        end
      end
`ifdef CALC1_SHIFT_EN
      4'd5: begin
        alu_resp = 2'd1;
        alu_data = alu_a << alu_b[27:31];
      end
      4'd6: begin
        alu_resp = 2'd1;
        alu_data = alu_a >> alu_b[27:31];
      end
`endif
      default: ;
    endcase
  end

  // NOTE: every next-state signal gets its hold/zero default before the case, so no path infers a latch.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      state_d[i] = state_q[i];
      cmd_d[i]   = cmd_q[i];
      op1_d[i]   = op1_q[i];
      op2_d[i]   = op2_q[i];
      resp_d[i]  = '0;
      res_d[i]   = '0;
      case (state_q[i])
        ST_IDLE: begin
          if (cmd_in[i] != '0) begin
            cmd_d[i]   = cmd_in[i];
            op1_d[i]   = data_in[i];
            state_d[i] = ST_OP2;
          end
        end
        ST_OP2: begin
          op2_d[i]   = data_in[i];
          state_d[i] = ST_PEND;
        end
        ST_PEND: begin
          if (grant_vld && grant_idx == 2'(i)) begin
            resp_d[i]  = alu_resp;
            res_d[i]   = alu_data;
            state_d[i] = ST_IDLE;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // NOTE: flops use non-blocking assignments so every port samples the same pre-edge values.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin
        state_q[i] <= ST_IDLE;
        cmd_q[i]   <= '0;
        op1_q[i]   <= '0;
        op2_q[i]   <= '0;
        resp_q[i]  <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        state_q[i] <= state_d[i];
        cmd_q[i]   <= cmd_d[i];
        op1_q[i]   <= op1_d[i];
        op2_q[i]   <= op2_d[i];
        resp_q[i]  <= resp_d[i];
        res_q[i]   <= res_d[i];
      end
    end
  end

  assign out_data1 = res_q[0];
  assign out_data2 = res_q[1];
  assign out_data3 = res_q[2];
  assign out_data4 = res_q[3];
  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
endmodule

// File: tb/tb_calc1_core.sv
// Self-checking bench for calc1_core: directed and randomized commands against an arithmetic reference model.
// Honours CALC1_SHIFT_EN the same way the design does.
module tb_calc1_core;
  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [0:3]  cmd  [4];
  logic [0:31] din  [4];
  logic [0:31] dout [4];
  logic [0:1]  resp [4];

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  v_cmd [4];
  logic [31:0] v_a   [4];
  logic [31:0] v_b   [4];

  calc1_core dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req1_cmd_in (cmd[0]),
    .req2_cmd_in (cmd[1]),
    .req3_cmd_in (cmd[2]),
    .req4_cmd_in (cmd[3]),
    .req1_data_in(din[0]),
    .req2_data_in(din[1]),
    .req3_data_in(din[2]),
    .req4_data_in(din[3]),
    .out_data1   (dout[0]),
    .out_data2   (dout[1]),
    .out_data3   (dout[2]),
    .out_data4   (dout[3]),
    .out_resp1   (resp[0]),
    .out_resp2   (resp[1]),
    .out_resp3   (resp[2]),
    .out_resp4   (resp[3])
  );

  always #5 c_clk = ~c_clk;

  // Reference: plain wide arithmetic on the command's meaning.
  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [1:0] r, output logic [31:0] d);
    longint unsigned la, lb;
    la = 64'(a);
    lb = 64'(b);
    r  = 2'd3;
    d  = 32'd0;
    if (c == 4'd1) begin
      if (la + lb > 64'hFFFF_FFFF) r = 2'd2;
      else begin r = 2'd1; d = 32'(la + lb); end
    end else if (c == 4'd2) begin
      if (lb > la) r = 2'd2;
      else begin r = 2'd1; d = 32'(la - lb); end
    end
`ifdef CALC1_SHIFT_EN
    else if (c == 4'd5) begin r = 2'd1; d = a << b[4:0]; end
    else if (c == 4'd6) begin r = 2'd1; d = a >> b[4:0]; end
`endif
  endfunction

  // Issue v_* on the masked ports in the same cycle; expect responses in port order, one per cycle,
  // starting three cycles after the command, and silence one cycle before and after.
  task automatic run_batch(input string name, input logic [3:0] mask);
    int rank [4];
    int n;
    logic [1:0]  er;
    logic [31:0] ed;
    n = 0;
    for (int p = 0; p < 4; p++) begin
      if (mask[p]) begin rank[p] = n; n++; end
      else rank[p] = -1;
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) if (mask[p]) begin cmd[p] = v_cmd[p]; din[p] = v_a[p]; end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin cmd[p] = '0; din[p] = mask[p] ? v_b[p] : $urandom(); end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) din[p] = $urandom();
    for (int k = -1; k <= n; k++) begin
      if (k >= 0) begin @(posedge c_clk); #1; end
      for (int p = 0; p < 4; p++) begin
        if (mask[p] && rank[p] == k) model(v_cmd[p], v_a[p], v_b[p], er, ed);
        else begin er = 2'd0; ed = 32'd0; end
        n_cmp++;
        if (resp[p] !== er || dout[p] !== ed) begin
          n_err++;
          $display("FAIL %s port%0d slot%0d: resp=%0d data=%h, expected resp=%0d data=%h",
                   name, p + 1, k, resp[p], dout[p], er, ed);
        end
      end
    end
    for (int p = 0; p < 4; p++) din[p] = '0;
  endtask

  task automatic single(input string name, input int p, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b);
    v_cmd[p] = c; v_a[p] = a; v_b[p] = b;
    run_batch(name, 4'(1 << p));
  endtask

  task automatic test_reset();
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd1; din[p] = 32'h1234_5678; end
    repeat (3) @(posedge c_clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      n_cmp++;
      if (resp[p] !== 2'd0 || dout[p] !== 32'd0) begin
        n_err++;
        $display("FAIL reset port%0d: resp=%0d data=%h, expected 0/0", p + 1, resp[p], dout[p]);
      end
    end
    for (int p = 0; p < 4; p++) begin cmd[p] = '0; din[p] = '0; end
    @(posedge c_clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_add();
    single("add_small", 0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
    single("add_mid",   0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    single("add_zero",  0, 4'd1, 32'h0,         32'h0);
    single("add_ovf",   0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    single("add_max",   2, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_sub();
    single("sub_under", 0, 4'd2, 32'd1,  32'd15);
    single("sub_ok",    0, 4'd2, 32'd15, 32'd1);
    single("sub_equal", 1, 4'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
  endtask

  task automatic test_invalid();
    single("cmd3", 0, 4'd3,  32'd1, 32'd1);
    single("cmd4", 0, 4'd4,  32'd1, 32'd1);
    single("cmd5", 0, 4'd5,  32'd1, 32'd1);
    single("cmd15", 3, 4'd15, 32'd7, 32'd9);
  endtask

  task automatic test_walking();
    for (int k = 0; k < 32; k++) single("walk_one", 0, 4'd1, 32'd1 << k, 32'd0);
  endtask

  task automatic test_shift();
    single("shl_31", 0, 4'd5, 32'd1,         32'd31);
    single("shr_4",  0, 4'd6, 32'h8000_0000, 32'd4);
    single("shl_hi", 1, 4'd5, 32'hF0F0_F0F0, 32'hFFFF_FFE4);
  endtask

  task automatic test_all_ports();
    for (int p = 0; p < 4; p++) begin
      v_cmd[p] = 4'd1;
      v_a[p]   = 32'h1000_0000 * (p + 1);
      v_b[p]   = 32'd100 + p;
    end
    run_batch("all_ports", 4'b1111);
  endtask

  task automatic test_back_to_back();
    @(posedge c_clk); #1;
    cmd[0] = 4'd1; din[0] = 32'd5;
    @(posedge c_clk); #1;
    cmd[0] = 4'd0; din[0] = 32'd7;
    @(posedge c_clk); #1;
    din[0] = 32'd0;
    n_cmp++;
    if (resp[0] !== 2'd0) begin n_err++; $display("FAIL b2b_early: resp=%0d, expected 0", resp[0]); end
    @(posedge c_clk); #1;
    n_cmp++;
    if (resp[0] !== 2'd1 || dout[0] !== 32'd12) begin
      n_err++; $display("FAIL b2b_first: resp=%0d data=%h, expected 1/0000000c", resp[0], dout[0]);
    end
    cmd[0] = 4'd2; din[0] = 32'd9;
    @(posedge c_clk); #1;
    cmd[0] = 4'd0; din[0] = 32'd4;
    n_cmp++;
    if (resp[0] !== 2'd0 || dout[0] !== 32'd0) begin
      n_err++; $display("FAIL b2b_gap: resp=%0d data=%h, expected 0/0", resp[0], dout[0]);
    end
    @(posedge c_clk); #1;
    din[0] = 32'd0;
    @(posedge c_clk); #1;
    n_cmp++;
    if (resp[0] !== 2'd1 || dout[0] !== 32'd5) begin
      n_err++; $display("FAIL b2b_second: resp=%0d data=%h, expected 1/00000005", resp[0], dout[0]);
    end
    @(posedge c_clk); #1;
  endtask

  task automatic test_reset_mid();
    @(posedge c_clk); #1;
    cmd[0] = 4'd1; din[0] = 32'd10;
    cmd[1] = 4'd1; din[1] = 32'd20;
    @(posedge c_clk); #1;
    cmd[0] = 4'd0; din[0] = 32'd1;
    cmd[1] = 4'd0; din[1] = 32'd2;
    @(posedge c_clk); #1;
    din[0] = '0; din[1] = '0;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) reset = 1'b1;
      #1;
      for (int p = 0; p < 4; p++) begin
        n_cmp++;
        if (resp[p] !== 2'd0 || dout[p] !== 32'd0) begin
          n_err++;
          $display("FAIL reset_mid c%0d port%0d: resp=%0d data=%h, expected 0/0", c, p + 1, resp[p], dout[p]);
        end
      end
      @(posedge c_clk); #1;
    end
    single("after_reset", 1, 4'd1, 32'd40, 32'd2);
  endtask

  task automatic test_random();
    logic [3:0] cmd_tab [8];
    cmd_tab = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd9};
    for (int it = 0; it < 30; it++) begin
      for (int p = 0; p < 4; p++) begin
        v_cmd[p] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : cmd_tab[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 1) begin
          v_a[p] = $urandom(); v_b[p] = $urandom();
        end else begin
          v_a[p] = $urandom_range(0, 40); v_b[p] = $urandom_range(0, 40);
        end
      end
      run_batch("random", 4'($urandom_range(1, 15)));
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin cmd[p] = '0; din[p] = '0; end
    test_reset();
    test_add();
    test_sub();
    test_invalid();
    test_walking();
    test_shift();
    test_all_ports();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
